multdiv_iter: RTL and testbench

//   Parametrised iterative multiply/divide unit for the processor execute stage;

---
 rtl/multdiv_iter_pkg.sv | 15 +
 rtl/multdiv_iter_core.sv | 54 +++++
 rtl/multdiv_iter.sv | 127 ++++++++++++
 tb/tb_multdiv_iter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package multdiv_iter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } op_t;

endpackage

// File: rtl/multdiv_iter_core.sv
// Unsigned radix-2 datapath: shift-add multiply or restoring divide, one step per enable.
// After WIDTH steps {hi,lo} is the product, or hi=remainder / lo=quotient.
module multdiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             load,
  input  logic             step,
  input  logic             op_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // acc carries one extra bit: the multiply carry-out and the divide shift-in overflow
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;

  always_comb begin
    add_sum = acc + (q[0] ? {1'b0, m} : '0);
    sh      = {acc[WIDTH-1:0], q[WIDTH-1]};
    diff    = {1'b0, sh} - {2'b00, m};
  end

  always_ff @(posedge clock) begin
    if (load) begin
      acc <= '0;
      q   <= a_mag;
      m   <= b_mag;
    end else if (step) begin
      if (op_div) begin
        if (!diff[WIDTH+1]) begin
          acc <= diff[WIDTH:0];
          q   <= {q[WIDTH-2:0], 1'b1};
        end else begin
          acc <= sh;
          q   <= {q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc <= {1'b0, add_sum[WIDTH:1]};
        q   <= {add_sum[0], q[WIDTH-1:1]};
      end
    end
  end

  assign hi = acc[WIDTH-1:0];
  assign lo = q;

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed/unsigned multiply/divide: FSM, sign handling and exceptions
// wrapped around the unsigned shift datapath.
module multdiv_iter
  import multdiv_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_signed,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_result_hi,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  op_t              op;
  logic [CNT_W-1:0] cnt;
  logic             sgn_mode, neg_lo, neg_hi, div_zero, div_ovf;

  logic             start, step, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, core_hi, core_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             mul_exc;

  assign start = ctrl_MULT | ctrl_DIV;
  assign step  = (state == S_RUN) & ~start;
  assign a_neg = ctrl_signed & data_operandA[WIDTH-1];
  assign b_neg = ctrl_signed & data_operandB[WIDTH-1];
  assign a_mag = a_neg ? -data_operandA : data_operandA;
  assign b_mag = b_neg ? -data_operandB : data_operandB;

  multdiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clock  (clock),
    .load   (start),
    .step   (step),
    .op_div (op == OP_DIV),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .hi     (core_hi),
    .lo     (core_lo)
  );

  // Sign correction on the magnitude result; neg_lo is product/quotient sign,
  // neg_hi is the remainder sign (follows the dividend).
  always_comb begin
    prod     = {core_hi, core_lo};
    prod_fix = neg_lo ? -prod : prod;
    mul_exc  = sgn_mode ? (prod_fix[2*WIDTH-1:WIDTH] != {WIDTH{prod_fix[WIDTH-1]}})
                        : (prod_fix[2*WIDTH-1:WIDTH] != '0);
    quo_fix  = neg_lo ? -core_lo : core_lo;
    rem_fix  = neg_hi ? -core_hi : core_hi;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      op             <= OP_MUL;
      cnt            <= '0;
      sgn_mode       <= 1'b0;
      neg_lo         <= 1'b0;
      neg_hi         <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_result_hi <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        // a new start always wins, abandoning any op in flight
        state    <= S_RUN;
        op       <= ctrl_MULT ? OP_MUL : OP_DIV;
        cnt      <= '0;
        sgn_mode <= ctrl_signed;
        neg_lo   <= a_neg ^ b_neg;
        neg_hi   <= a_neg;
        div_zero <= (data_operandB == '0);
        div_ovf  <= ctrl_signed & (data_operandA == MIN_VAL) & (data_operandB == '1);
        busy     <= 1'b1;
      end else begin
        case (state)
          S_RUN: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIX;
          end
          S_FIX: begin
            state          <= S_IDLE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            if (op == OP_MUL) begin
              data_result    <= prod_fix[WIDTH-1:0];
              data_result_hi <= prod_fix[2*WIDTH-1:WIDTH];
              data_exception <= mul_exc;
            end else if (div_zero) begin
              data_result    <= '0;
              data_result_hi <= '0;
              data_exception <= 1'b1;
            end else if (div_ovf) begin
              data_result    <= MIN_VAL;
              data_result_hi <= '0;
              data_exception <= 1'b1;
            end else begin
              data_result    <= quo_fix;
              data_result_hi <= rem_fix;
              data_exception <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Scoreboard bench for multdiv_iter at WIDTH=32 and WIDTH=8.
module tb_multdiv_iter;

  localparam int LAT   = 33;
  localparam int LAT8  = 9;

  typedef struct { logic [31:0] res; logic [31:0] hi; logic exc; } exp_t;
  typedef struct { logic [7:0] res; logic [7:0] hi; logic exc; } exp8_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic        mult = 1'b0, div = 1'b0, sgn = 1'b0;
  logic [31:0] res, hi;
  logic        exc, rdy, busy;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        mult8 = 1'b0, div8 = 1'b0, sgn8 = 1'b0;
  logic [7:0]  res8, hi8;
  logic        exc8, rdy8, busy8;

  exp_t  exp_q[$];
  exp8_t exp8_q[$];
  int    n_checks = 0;
  int    n_pass = 0;

  always #5 clock = ~clock;

  multdiv_iter #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .data_operandA(a), .data_operandB(b),
    .ctrl_MULT(mult), .ctrl_DIV(div), .ctrl_signed(sgn),
    .data_result(res), .data_result_hi(hi), .data_exception(exc),
    .data_resultRDY(rdy), .busy(busy)
  );

  multdiv_iter #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .data_operandA(a8), .data_operandB(b8),
    .ctrl_MULT(mult8), .ctrl_DIV(div8), .ctrl_signed(sgn8),
    .data_result(res8), .data_result_hi(hi8), .data_exception(exc8),
    .data_resultRDY(rdy8), .busy(busy8)
  );

  function automatic exp_t mk(input logic [31:0] r, input logic [31:0] h, input logic e);
    exp_t x;
    x.res = r; x.hi = h; x.exc = e;
    return x;
  endfunction

  // Behavioural reference built on native 64-bit / int arithmetic
  function automatic exp_t model(input logic d, input logic s, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    int qi, ri;
    if (!d) begin
      if (s) p = longint'($signed(x)) * longint'($signed(y));
      else   p = {32'd0, x} * {32'd0, y};
      return mk(p[31:0], p[63:32], s ? (p[63:32] != {32{p[31]}}) : (p[63:32] != 32'd0));
    end
    if (y == 32'd0) return mk(32'd0, 32'd0, 1'b1);
    if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return mk(32'h8000_0000, 32'd0, 1'b1);
    if (s) begin
      qi = $signed(x) / $signed(y);
      ri = $signed(x) % $signed(y);
      return mk(qi, ri, 1'b0);
    end
    return mk(x / y, x % y, 1'b0);
  endfunction

  task automatic start_op(input logic d, input logic s, input logic [31:0] x, input logic [31:0] y, input logic both);
    a = x; b = y; sgn = s;
    mult = !d || both;
    div  = d || both;
    @(posedge clock); #1;
    mult = 1'b0; div = 1'b0;
  endtask

  task automatic wait_rdy(output int edges, output bit busy_ok);
    edges = -1; busy_ok = 1'b1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clock); #1;
      if (rdy) begin
        edges = n;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({res, hi, exc, rdy, busy} !== '0)
      $display("FAIL reset32 got res=%h hi=%h exc=%b rdy=%b busy=%b want all 0", res, hi, exc, rdy, busy);
    else n_pass++;
    n_checks++;
    if ({res8, hi8, exc8, rdy8, busy8} !== '0)
      $display("FAIL reset8 got res=%h hi=%h exc=%b rdy=%b busy=%b want all 0", res8, hi8, exc8, rdy8, busy8);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_op(input string nm, input logic d, input logic s, input logic [31:0] x,
                         input logic [31:0] y, input exp_t e, input logic both = 1'b0);
    int edges;
    bit bok;
    exp_t w;
    exp_q.push_back(e);
    start_op(d, s, x, y, both);
    wait_rdy(edges, bok);
    n_checks++;
    if (edges !== LAT) $display("FAIL %s latency got %0d want %0d", nm, edges, LAT); else n_pass++;
    n_checks++;
    if (bok !== 1'b1) $display("FAIL %s busy got dropout want high until rdy", nm); else n_pass++;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s scoreboard got empty want entry", nm);
      return;
    end
    n_pass++;
    w = exp_q.pop_front();
    n_checks++;
    if (res !== w.res) $display("FAIL %s result got %h want %h", nm, res, w.res); else n_pass++;
    n_checks++;
    if (hi !== w.hi) $display("FAIL %s result_hi got %h want %h", nm, hi, w.hi); else n_pass++;
    n_checks++;
    if (exc !== w.exc) $display("FAIL %s exception got %b want %b", nm, exc, w.exc); else n_pass++;
    @(posedge clock); #1;
    n_checks++;
    if ({rdy, res, hi, exc} !== {1'b0, w.res, w.hi, w.exc})
      $display("FAIL %s hold got rdy=%b res=%h want rdy=0 res=%h", nm, rdy, res, w.res);
    else n_pass++;
  endtask

  task automatic test_spec_cases();
    test_op("smul_m7x6",   1'b0, 1'b1, 32'hFFFF_FFF9, 32'd6,         mk(32'hFFFF_FFD6, 32'hFFFF_FFFF, 1'b0));
    test_op("sdiv_m7d2",   1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,         mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0));
    test_op("udiv_7d2",    1'b1, 1'b0, 32'd7,         32'd2,         mk(32'd3, 32'd1, 1'b0));
    test_op("sdiv_7dm2",   1'b1, 1'b1, 32'd7,         32'hFFFF_FFFE, mk(32'hFFFF_FFFD, 32'd1, 1'b0));
    test_op("sdiv_5d0",    1'b1, 1'b1, 32'd5,         32'd0,         mk(32'd0, 32'd0, 1'b1));
    test_op("udiv_5d0",    1'b1, 1'b0, 32'd5,         32'd0,         mk(32'd0, 32'd0, 1'b1));
    test_op("sdiv_min_m1", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h8000_0000, 32'd0, 1'b1));
    test_op("udiv_min_m1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'd0, 32'h8000_0000, 1'b0));
    test_op("umul_ovf",    1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, mk(32'd0, 32'd1, 1'b1));
    test_op("smul_m1xm1",  1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'd1, 32'd0, 1'b0));
    test_op("umul_max",    1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mk(32'd1, 32'hFFFF_FFFE, 1'b1));
    test_op("smul_minxmin",1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, mk(32'd0, 32'h4000_0000, 1'b1));
    test_op("both_mul",    1'b1, 1'b0, 32'd6,         32'd7,         mk(32'd42, 32'd0, 1'b0), 1'b1);
  endtask

  task automatic test_random();
    logic d, s;
    logic [31:0] x, y;
    for (int i = 0; i < 16; i++) begin
      d = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      y = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      test_op($sformatf("rand%0d", i), d, s, x, y, model(d, s, x, y));
    end
  endtask

  task automatic test_restart();
    int edges;
    bit bok, early, late;
    exp_t w;
    exp_q.push_back(mk(32'd14, 32'd2, 1'b0));
    start_op(1'b0, 1'b0, 32'd3, 32'd4, 1'b0);
    early = 1'b0;
    repeat (9) begin @(posedge clock); #1; if (rdy) early = 1'b1; end
    start_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
    wait_rdy(edges, bok);
    n_checks++;
    if (early !== 1'b0) $display("FAIL restart early_rdy got 1 want 0"); else n_pass++;
    n_checks++;
    if (edges !== LAT) $display("FAIL restart latency got %0d want %0d", edges, LAT); else n_pass++;
    w = exp_q.pop_front();
    n_checks++;
    if ({res, hi, exc} !== {w.res, w.hi, w.exc})
      $display("FAIL restart result got %h/%h/%b want %h/%h/%b", res, hi, exc, w.res, w.hi, w.exc);
    else n_pass++;
    late = 1'b0;
    repeat (40) begin @(posedge clock); #1; if (rdy) late = 1'b1; end
    n_checks++;
    if (late !== 1'b0) $display("FAIL restart extra_rdy got 1 want 0"); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int e1, e2;
    bit b1, b2;
    exp_t w;
    exp_q.push_back(model(1'b0, 1'b0, 32'd123456, 32'd789));
    exp_q.push_back(model(1'b1, 1'b1, 32'hFFFF_F000, 32'd9));
    start_op(1'b0, 1'b0, 32'd123456, 32'd789, 1'b0);
    wait_rdy(e1, b1);
    w = exp_q.pop_front();
    n_checks++;
    if ({e1, res} !== {LAT, w.res}) $display("FAIL b2b first got %0d/%h want %0d/%h", e1, res, LAT, w.res);
    else n_pass++;
    start_op(1'b1, 1'b1, 32'hFFFF_F000, 32'd9, 1'b0);
    n_checks++;
    if ({res, rdy, busy} !== {w.res, 1'b0, 1'b1})
      $display("FAIL b2b hold got res=%h rdy=%b busy=%b want res=%h rdy=0 busy=1", res, rdy, busy, w.res);
    else n_pass++;
    wait_rdy(e2, b2);
    w = exp_q.pop_front();
    n_checks++;
    if ({e2, res, hi, exc} !== {LAT, w.res, w.hi, w.exc})
      $display("FAIL b2b second got %0d/%h/%h/%b want %0d/%h/%h/%b", e2, res, hi, exc, LAT, w.res, w.hi, w.exc);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    start_op(1'b0, 1'b1, 32'h0001_2345, 32'h0000_0777, 1'b0);
    repeat (4) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if ({res, hi, exc, rdy, busy} !== '0)
      $display("FAIL reset_mid got res=%h hi=%h exc=%b rdy=%b busy=%b want all 0", res, hi, exc, rdy, busy);
    else n_pass++;
    reset = 1'b0;
    seen = 1'b0;
    repeat (50) begin @(posedge clock); #1; if (rdy) seen = 1'b1; end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL reset_mid rdy_after got 1 want 0"); else n_pass++;
  endtask

  task automatic test_w8();
    logic [7:0] ta[4], tb[4], tr[4], th[4];
    logic       ts[4], te[4];
    int edges;
    exp8_t w, x;
    ta = '{8'h7F, 8'hFF, 8'h10, 8'hF9};
    tb = '{8'h02, 8'hFF, 8'h10, 8'h06};
    ts = '{1'b1,  1'b1,  1'b0,  1'b1};
    tr = '{8'hFE, 8'h01, 8'h00, 8'hD6};
    th = '{8'h00, 8'h00, 8'h01, 8'hFF};
    te = '{1'b1,  1'b0,  1'b1,  1'b0};
    for (int i = 0; i < 4; i++) begin
      x.res = tr[i]; x.hi = th[i]; x.exc = te[i];
      exp8_q.push_back(x);
      a8 = ta[i]; b8 = tb[i]; sgn8 = ts[i]; mult8 = 1'b1;
      @(posedge clock); #1;
      mult8 = 1'b0;
      edges = -1;
      for (int n = 1; n <= 50; n++) begin
        @(posedge clock); #1;
        if (rdy8) begin edges = n; break; end
      end
      n_checks++;
      if (edges !== LAT8) $display("FAIL w8_%0d latency got %0d want %0d", i, edges, LAT8); else n_pass++;
      w = exp8_q.pop_front();
      n_checks++;
      if ({res8, hi8, exc8} !== {w.res, w.hi, w.exc})
        $display("FAIL w8_%0d result got %h/%h/%b want %h/%h/%b", i, res8, hi8, exc8, w.res, w.hi, w.exc);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_spec_cases();
    test_random();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    test_w8();
    n_checks++;
    if (exp_q.size() + exp8_q.size() !== 0)
      $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size() + exp8_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
